// File: rtl/multi_mux_stream.sv
// Packet-level N:1 AXI-Stream merger. A grant is held for a whole packet and
// beats pass through a single registered output stage.

module multi_mux_stream_lane #(
  parameter int WIDTH      = 16,
  parameter int USER_WIDTH = 2,
  parameter int SELW       = 2,
  parameter int IDX        = 0
) (
  input  logic                  active,
  input  logic [SELW-1:0]       grant,
  input  logic                  room,
  input  logic                  valid,
  input  logic [WIDTH-1:0]      data,
  input  logic [USER_WIDTH-1:0] user,
  input  logic                  last,
  output logic                  ready,
  output logic                  take,
  output logic [WIDTH-1:0]      data_m,
  output logic [USER_WIDTH-1:0] user_m,
  output logic                  last_m
);
  logic sel;

  // Masked outputs let the top merge all lanes with a plain OR.
  assign sel    = active && (grant == SELW'(IDX));
  assign ready  = sel && room;
  assign take   = ready && valid;
  assign data_m = sel ? data : '0;
  assign user_m = sel ? user : '0;
  assign last_m = sel && last;
endmodule

module multi_mux_stream #(
  parameter int WIDTH      = 16,
  parameter int USER_WIDTH = 2,
  parameter int INPUTS     = 4,
  parameter int PRIO       = 0,
  localparam int SELW      = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic [WIDTH*INPUTS-1:0]      i_tdata,
  input  logic [USER_WIDTH*INPUTS-1:0] i_tuser,
  input  logic [INPUTS-1:0]            i_tlast,
  input  logic [INPUTS-1:0]            i_tvalid,
  output logic [INPUTS-1:0]            i_tready,
  output logic [WIDTH-1:0]             o_tdata,
  output logic [USER_WIDTH-1:0]        o_tuser,
  output logic                         o_tlast,
  output logic                         o_tvalid,
  input  logic                         o_tready,
  output logic [SELW-1:0]              o_tsel
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [SELW-1:0] LAST_INIT = SELW'(INPUTS - 1);

  state_t          state_q, state_d;
  logic [SELW-1:0] grant_q, grant_d, last_q, last_d, arb_sel;
  logic            arb_hit, room, take, active;

  logic [INPUTS-1:0]                 lane_take, lane_last;
  logic [INPUTS-1:0][WIDTH-1:0]      lane_data;
  logic [INPUTS-1:0][USER_WIDTH-1:0] lane_user;
  logic [WIDTH-1:0]                  mux_data;
  logic [USER_WIDTH-1:0]             mux_user;
  logic                              mux_last;

  assign active = (state_q == ACTIVE);
  assign room   = !o_tvalid || o_tready;

  for (genvar n = 0; n < INPUTS; n++) begin : g_lane
    multi_mux_stream_lane #(
      .WIDTH(WIDTH), .USER_WIDTH(USER_WIDTH), .SELW(SELW), .IDX(n)
    ) u_lane (
      .active (active),
      .grant  (grant_q),
      .room   (room),
      .valid  (i_tvalid[n]),
      .data   (i_tdata[WIDTH*n +: WIDTH]),
      .user   (i_tuser[USER_WIDTH*n +: USER_WIDTH]),
      .last   (i_tlast[n]),
      .ready  (i_tready[n]),
      .take   (lane_take[n]),
      .data_m (lane_data[n]),
      .user_m (lane_user[n]),
      .last_m (lane_last[n])
    );
  end

  always_comb begin
    mux_data = '0;
    mux_user = '0;
    for (int n = 0; n < INPUTS; n++) begin
      mux_data = mux_data | lane_data[n];
      mux_user = mux_user | lane_user[n];
    end
    mux_last = |lane_last;
    take     = |lane_take;
  end

  // Loops run from lowest to highest priority so the last hit wins.
  always_comb begin
    int idx;
    arb_hit = |i_tvalid;
    arb_sel = '0;
    idx     = 0;
    if (PRIO != 0) begin
      for (int i = INPUTS - 1; i >= 0; i--)
        if (i_tvalid[i]) arb_sel = SELW'(i);
    end else begin
      for (int k = INPUTS; k >= 1; k--) begin
        idx = (int'(last_q) + k) % INPUTS;
        if (i_tvalid[idx]) arb_sel = SELW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_INIT;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (clear) begin
      state_d = IDLE;
      last_d  = LAST_INIT;
    end else begin
      case (state_q)
        IDLE: if (arb_hit) begin
          state_d = ACTIVE;
          grant_d = arb_sel;
        end
        ACTIVE: if (take && mux_last) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A load in the same cycle as a drain replaces the old beat without a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tuser  <= '0;
      o_tlast  <= 1'b0;
      o_tsel   <= '0;
    end else if (clear) begin
      o_tvalid <= 1'b0;
    end else if (take) begin
      o_tvalid <= 1'b1;
      o_tdata  <= mux_data;
      o_tuser  <= mux_user;
      o_tlast  <= mux_last;
      o_tsel   <= grant_q;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end
endmodule
